// File: rtl/fifo_stream_out_pkg.sv
// Shared widths and field offsets for the FIFO output stream stage and the sinks
// that unpack its {leaf, port, payload} words.
package fifo_stream_out_pkg;

  function automatic int unsigned hdr_bits(int unsigned leaf_bits, int unsigned port_bits);
    return leaf_bits + port_bits;
  endfunction

  function automatic int unsigned word_bits(int unsigned payload_bits, int unsigned leaf_bits,
                                            int unsigned port_bits);
    return payload_bits + hdr_bits(leaf_bits, port_bits);
  endfunction

  // Field offsets inside an outgoing word; payload always sits at bit 0.
  localparam int unsigned PayloadLsb = 0;

  function automatic int unsigned port_lsb(int unsigned payload_bits);
    return payload_bits;
  endfunction

  function automatic int unsigned leaf_lsb(int unsigned payload_bits, int unsigned port_bits);
    return payload_bits + port_bits;
  endfunction

  localparam int unsigned DefPayloadBits = 32;
  localparam int unsigned DefLeafBits    = 5;
  localparam int unsigned DefPortBits    = 4;
  localparam int unsigned DefWordBits    = word_bits(DefPayloadBits, DefLeafBits, DefPortBits);

endpackage

// File: rtl/fifo_stream_out_if.sv
// Valid/ack output stream carrying {leaf, port, payload} words.
interface fifo_stream_out_if
  import fifo_stream_out_pkg::*;
#(
  parameter int unsigned WORD_BITS = DefWordBits
) ();

  logic [WORD_BITS-1:0] dout;
  logic                 val_out;
  logic                 ack_in;

  modport master (output dout, output val_out, input ack_in);
  modport slave  (input dout, input val_out, output ack_in);

endinterface

// File: rtl/fifo_stream_out_skid2.sv
// Two-slot in-order buffer: s0 is the head; a push lands in the first slot left free
// after any same-cycle pop.
module stream_skid2 #(
  parameter int unsigned WORD_BITS = 41
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [WORD_BITS-1:0] push_data,
  input  logic                 pop,
  output logic [WORD_BITS-1:0] head,
  output logic [1:0]           occ
);

  logic [WORD_BITS-1:0] s0_q, s0_d, s1_q, s1_d;
  logic [1:0]           occ_q, occ_d;
  logic [1:0]           slot;

  always_comb begin
    s0_d  = s0_q;
    s1_d  = s1_q;
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    slot  = occ_q - {1'b0, pop};
    if (pop) begin
      s0_d = s1_q;
    end
    if (push) begin
      if (slot == 2'd0) begin
        s0_d = push_data;
      end else begin
        s1_d = push_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q  <= '0;
      s1_q  <= '0;
      occ_q <= 2'd0;
    end else begin
      s0_q  <= s0_d;
      s1_q  <= s1_d;
      occ_q <= occ_d;
    end
  end

  assign head = s0_q;
  assign occ  = occ_q;

endmodule

// File: rtl/fifo_stream_out.sv
// Drains a one-cycle-latency FIFO into a valid/ack stream, tagging each word with the
// destination header present when its data is captured.
module fifo_stream_out
  import fifo_stream_out_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS = 32,
  parameter int unsigned LEAF_BITS    = 5,
  parameter int unsigned PORT_BITS    = 4,
  parameter int unsigned CNT_BITS     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PAYLOAD_BITS-1:0] fifo_rdata,
  input  logic                    fifo_rempty,
  output logic                    fifo_rinc,
  input  logic [LEAF_BITS-1:0]    dst_leaf,
  input  logic [PORT_BITS-1:0]    dst_port,
  fifo_stream_out_if.master       strm,
  output logic [CNT_BITS-1:0]     word_cnt
);

  localparam int unsigned WordBits = word_bits(PAYLOAD_BITS, LEAF_BITS, PORT_BITS);

  logic [1:0]          occ;
  logic                pop;
  logic                infl_q;
  logic [2:0]          fill;
  logic [WordBits-1:0] cap_word;
  logic [WordBits-1:0] head;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  assign strm.val_out = (occ != 2'd0);
  assign strm.dout    = head;
  assign pop          = strm.val_out & strm.ack_in;
  assign cap_word     = {dst_leaf, dst_port, fifo_rdata};

  // Slots committed after this edge; never pull a word that would have nowhere to land.
  always_comb begin
    fill      = {1'b0, occ} + {2'b00, infl_q} - {2'b00, pop};
    fifo_rinc = rst_n & ~fifo_rempty & (fill < 3'd2);
    cnt_d     = cnt_q + {{(CNT_BITS-1){1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      infl_q <= fifo_rinc;
      cnt_q  <= cnt_d;
    end
  end

  assign word_cnt = cnt_q;

  stream_skid2 #(
    .WORD_BITS (WordBits)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (infl_q),
    .push_data (cap_word),
    .pop       (pop),
    .head      (head),
    .occ       (occ)
  );

endmodule

// File: tb/tb_fifo_stream_out.sv
// Bench for fifo_stream_out: FIFO model plus a queue-based expected-stream scoreboard,
// run against a 32-bit and a 4-bit counter instance sharing one stimulus.
module tb_fifo_stream_out;
  import fifo_stream_out_pkg::*;

  localparam int unsigned PB      = 32;
  localparam int unsigned LB      = 5;
  localparam int unsigned POB     = 4;
  localparam int unsigned WB      = word_bits(PB, LB, POB);
  localparam int unsigned PortLsb = port_lsb(PB);

  logic           clk = 1'b0;
  logic           rst_n;
  logic [PB-1:0]  fifo_rdata;
  logic           fifo_rempty;
  logic           fifo_rinc0, fifo_rinc1;
  logic [LB-1:0]  dst_leaf;
  logic [POB-1:0] dst_port;
  logic           ack;
  logic [31:0]    cnt0;
  logic [3:0]     cnt1;

  always #5 clk = ~clk;

  fifo_stream_out_if #(.WORD_BITS(WB)) s0 ();
  fifo_stream_out_if #(.WORD_BITS(WB)) s1 ();
  assign s0.ack_in = ack;
  assign s1.ack_in = ack;

  fifo_stream_out #(
    .PAYLOAD_BITS (PB), .LEAF_BITS (LB), .PORT_BITS (POB), .CNT_BITS (32)
  ) u_dut (
    .clk (clk), .rst_n (rst_n), .fifo_rdata (fifo_rdata), .fifo_rempty (fifo_rempty),
    .fifo_rinc (fifo_rinc0), .dst_leaf (dst_leaf), .dst_port (dst_port), .strm (s0),
    .word_cnt (cnt0)
  );

  fifo_stream_out #(
    .PAYLOAD_BITS (PB), .LEAF_BITS (LB), .PORT_BITS (POB), .CNT_BITS (4)
  ) u_dut4 (
    .clk (clk), .rst_n (rst_n), .fifo_rdata (fifo_rdata), .fifo_rempty (fifo_rempty),
    .fifo_rinc (fifo_rinc1), .dst_leaf (dst_leaf), .dst_port (dst_port), .strm (s1),
    .word_cnt (cnt1)
  );

  // Reference state: FIFO contents, captured-but-undelivered words, pending read.
  logic [PB-1:0]  fifo_q[$];
  logic [WB-1:0]  exp_q[$];
  logic [POB-1:0] popped_port[$];
  bit             pend;
  int unsigned    delivered;
  int             n_vec, n_err;
  int             rinc_pulses, run, max_run;

  typedef struct packed {
    logic        ack;
    logic        val;
    logic        rinc;
    logic [31:0] pay;
    logic [31:0] cnt;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [PB-1:0] w);
    fifo_q.push_back(w);
    fifo_rempty = 1'b0;
  endtask

  task automatic clear_model();
    fifo_q.delete();
    exp_q.delete();
    popped_port.delete();
    fifo_rempty = 1'b1;
    fifo_rdata  = '0;
    pend        = 1'b0;
    delivered   = 0;
    rinc_pulses = 0;
    run         = 0;
    max_run     = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ack   = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: check outputs against the model, then advance model and FIFO.
  task automatic tick();
    logic          ev, pop, e_rinc, rinc_act;
    logic [WB-1:0] cap;
    int            fill;
    #1;
    ev     = (exp_q.size() > 0);
    pop    = ev && ack;
    fill   = exp_q.size() + int'(pend) - int'(pop);
    e_rinc = !fifo_rempty && (fill < 2);
    chk("val_out", {s0.val_out, s1.val_out}, {ev, ev});
    if (ev) begin
      chk("dout", s0.dout, exp_q[0]);
      chk("dout_cnt4", s1.dout, exp_q[0]);
    end
    chk("fifo_rinc", {fifo_rinc0, fifo_rinc1}, {e_rinc, e_rinc});
    chk("rinc_when_empty", fifo_rinc0 & fifo_rempty, 0);
    chk("word_cnt", cnt0, delivered);
    chk("word_cnt4", cnt1, delivered % 16);
    chk("capture_pop_full", (pend && exp_q.size() == 2), 0);
    rinc_act = fifo_rinc0;
    if (rinc_act) rinc_pulses++;
    cap = {dst_leaf, dst_port, fifo_rdata};
    if (pop) popped_port.push_back(s0.dout[PortLsb +: POB]);
    if (s0.val_out) begin
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    @(posedge clk);
    if (pop) begin
      void'(exp_q.pop_front());
      delivered++;
    end
    if (pend) exp_q.push_back(cap);
    pend = rinc_act;
    #1;
    if (rinc_act && fifo_q.size() > 0) fifo_rdata = fifo_q.pop_front();
    fifo_rempty = (fifo_q.size() == 0);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned pushed, cycles;
    n_vec    = 0;
    n_err    = 0;
    dst_leaf = 5'd3;
    dst_port = 4'd2;
    // Directed latency/backpressure sequence with three preloaded words.
    tbl[0] = '{1'b0, 1'b0, 1'b1, 32'h0,  32'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 32'h0,  32'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 32'hA5, 32'd0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 32'hA5, 32'd0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 32'hA5, 32'd0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'hB6, 32'd1};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 32'hC7, 32'd2};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 32'h0,  32'd3};

    do_reset();
    chk("reset_val", s0.val_out, 0);
    chk("reset_cnt", cnt0, 0);
    chk("reset_dout", s0.dout, 0);
    push_word(32'hA5);
    push_word(32'hB6);
    push_word(32'hC7);
    for (int i = 0; i < 8; i++) begin
      ack = tbl[i].ack;
      #1;
      chk("tbl_val", s0.val_out, tbl[i].val);
      chk("tbl_rinc", fifo_rinc0, tbl[i].rinc);
      chk("tbl_cnt", cnt0, tbl[i].cnt);
      if (tbl[i].val) chk("tbl_dout", s0.dout, {5'd3, 4'd2, tbl[i].pay});
      tick();
    end

    // Streaming at full rate.
    do_reset();
    for (int i = 0; i < 100; i++) push_word(i);
    ack = 1'b1;
    repeat (110) tick();
    chk("stream_run", max_run, 100);
    chk("stream_cnt", cnt0, 100);

    // Full backpressure then drain.
    do_reset();
    for (int i = 0; i < 10; i++) push_word(32'h100 + i);
    ack = 1'b0;
    repeat (20) tick();
    chk("bp_rinc_pulses", rinc_pulses, 2);
    chk("bp_val", s0.val_out, 1);
    chk("bp_dout", s0.dout, {5'd3, 4'd2, 32'h100});
    ack = 1'b1;
    repeat (20) tick();
    chk("bp_cnt", cnt0, 10);

    // Random ack, bursty FIFO fill and changing headers.
    do_reset();
    pushed = 0;
    cycles = 0;
    while (delivered < 1000 && cycles < 20000) begin
      if (pushed < 1000 && $urandom_range(0, 3) != 0) begin
        push_word($urandom);
        pushed++;
      end
      ack = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        dst_leaf = 5'($urandom);
        dst_port = 4'($urandom);
      end
      tick();
      cycles++;
    end
    chk("rand_delivered", delivered, 1000);
    dst_leaf = 5'd3;
    dst_port = 4'd2;

    // Asynchronous reset with two words buffered and no read in flight.
    do_reset();
    for (int i = 0; i < 4; i++) push_word(32'h11 + i);
    ack = 1'b1;
    repeat (4) tick();
    ack = 1'b0;
    repeat (2) tick();
    chk("pre_rst_cnt", cnt0, 2);
    chk("pre_rst_val", s0.val_out, 1);
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("rst_val", {s0.val_out, s1.val_out}, 0);
    chk("rst_rinc", {fifo_rinc0, fifo_rinc1}, 0);
    chk("rst_dout", s0.dout, 0);
    chk("rst_cnt", {cnt0, cnt1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    push_word(32'h77);
    ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rst_latency_val", s0.val_out, (i == 2));
      tick();
    end

    // Header change while buffered, and 4-bit counter wrap.
    do_reset();
    push_word(32'h201);
    push_word(32'h202);
    ack = 1'b0;
    repeat (4) tick();
    dst_port = 4'd7;
    for (int i = 0; i < 15; i++) push_word(32'h300 + i);
    ack = 1'b1;
    repeat (30) tick();
    chk("hdr_size", popped_port.size(), 17);
    if (popped_port.size() >= 17) begin
      chk("hdr_port0", popped_port[0], 2);
      chk("hdr_port1", popped_port[1], 2);
      chk("hdr_port2", popped_port[2], 7);
      chk("hdr_port16", popped_port[16], 7);
    end
    chk("wrap_cnt4", cnt1, 1);
    chk("wrap_cnt32", cnt0, 17);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_stream_out.md
# fifo_stream_out

Output-side stream stage that drains a synchronous FIFO with a one-cycle read latency and presents its contents as a valid/ack stream toward the network interface. Each word is tagged with a runtime-configured destination header (leaf address and port), so the outgoing word is `{dst_leaf, dst_port, payload}`. A two-entry output buffer with in-flight read tracking sustains one word per cycle without ever over-reading the FIFO or dropping data under backpressure. A free-running counter reports delivered words.

## Interface
Parameters:
- `PAYLOAD_BITS`, 32: FIFO payload width.
- `LEAF_BITS`, 5: destination leaf address width.
- `PORT_BITS`, 4: destination port width.
- `CNT_BITS`, 32: width of the word counter.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, input, 1: sole clock; all state is on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `fifo_rdata`, input, PAYLOAD_BITS: FIFO read data, valid the cycle after a `fifo_rinc` pulse.
- `fifo_rempty`, input, 1: FIFO empty flag.
- `fifo_rinc`, output, 1: FIFO pop request.
- `dst_leaf`, input, LEAF_BITS: header leaf field, sampled at capture.
- `dst_port`, input, PORT_BITS: header port field, sampled at capture.
- `dout`, output, LEAF_BITS+PORT_BITS+PAYLOAD_BITS: the head word, `{leaf, port, payload}`.
- `val_out`, output, 1: `dout` is valid.
- `ack_in`, input, 1: downstream accepts `dout` this cycle.
- `word_cnt`, output, CNT_BITS: count of delivered words.

## Operation
- **State:**
  - Two storage slots `s0` (head) and `s1`.
  - `occ` in 0..2 gives the number of filled slots.
  - `infl` (1 bit) is set when a read was issued last cycle and its data is due now.
- **Read issue:** `fifo_rinc = !fifo_rempty && (occ + infl - pop) < 2`, where `pop = val_out && ack_in`. This is combinational.
- **Capture:** when `infl` is 1, the word `{dst_leaf, dst_port, fifo_rdata}` is written into the first free slot after any pop this cycle is applied.
- **Pop:** when `pop` is 1, `s1` shifts into `s0` (or the captured word goes directly into `s0` if `occ` was 1).
- **Outputs:**
  - `val_out = (occ != 0)`.
  - `dout = s0`.
  - `dout` is held stable while `val_out && !ack_in`.
- **Occupancy update:**
  - `occ_next = occ + infl - pop`.
  - `infl_next = fifo_rinc`.
  - The invariant `occ + infl <= 2` must always hold.
- **Counter:** `word_cnt` increments on every `pop` and wraps modulo 2^CNT_BITS.
- **Reset** (asynchronous, any time, including mid-transfer):
  - `occ`, `infl` and `word_cnt` clear to 0.
  - `val_out` = 0, `fifo_rinc` = 0 during reset, `dout` = 0.
  - A read in flight at reset is discarded. The FIFO shares `rst_n` and is also cleared.
- **Header changes:** changing `dst_*` affects only words captured afterwards. Words already buffered keep their header.

## Timing
- **Latency:** with `fifo_rinc` high in cycle N, data is valid in N+1, captured at the end of N+1, and `val_out` is high in N+2. The empty-to-output latency is 2 cycles.
- **Throughput:** sustained 1 word per cycle while the FIFO is non-empty and `ack_in` = 1. The steady state is `occ` = 1, `infl` = 1.
- **Full backpressure** (`ack_in` = 0 with `occ` = 2): `fifo_rinc` = 0. At most 2 words are ever pulled ahead of acceptance.
- **Simultaneous capture and pop with `occ` = 2:** the invariant makes this impossible (`infl` must be 0). Assert it in the bench.
- **FIFO empties mid-stream:** buffered words still drain, and `val_out` drops the cycle after the last pop.
- **Counter wrap:** when a pop occurs with `word_cnt` = 2^CNT_BITS-1, the counter goes to 0 in the same cycle; no flag is raised.

## Structure
- A shared package holds:
  - the header width function `hdr_bits(LEAF_BITS, PORT_BITS)`,
  - the output word width,
  - the field offset constants used by the sinks that unpack `dout`.
- One sub-module, `stream_skid2`: the two-slot buffer with push, pop, `occ`, and the head output. The top level contains read-issue control, `infl`, header concatenation, and the counter.

## Test plan
- **Latency:** reset, then preload the FIFO with 0xA5 and `dst_leaf` = 3, `dst_port` = 2, `ack_in` = 1. Required: `val_out` high exactly 2 cycles after the first `fifo_rinc`, and `dout` = {5'd3, 4'd2, 32'hA5}.
- **Streaming:** stream 100 words 0..99 with `ack_in` held 1. Required: 100 consecutive valid cycles, in order, and `word_cnt` = 100.
- **Backpressure:** hold `ack_in` = 0 with 10 words in the FIFO. Required: exactly 2 `fifo_rinc` pulses, then none. `dout` stable, `occ` = 2. After release, all 10 words are delivered in order.
- **Random ack:** apply random `ack_in` (50%) over 1000 words. Required:
  - scoreboard match,
  - `occ + infl <= 2` every cycle,
  - no `fifo_rinc` while `fifo_rempty` is high.
- **Reset mid-transfer:** assert `rst_n` low while `occ` = 2 and `infl` = 0. Required: `val_out`, `fifo_rinc`, `dout` and `word_cnt` are 0 asynchronously. After release, the first new word appears at the 2-cycle latency.
- **Header change and wrap:** change `dst_port` 2→7 while 2 words are buffered. Required: those 2 keep port 2 and later words carry 7. With CNT_BITS = 4, 17 pops give `word_cnt` = 1.
